// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the block-RAM FIFO.
// - MODE_* : TDP36K aspect-ratio mode encodings.
// - width_to_mode  : maps a data width to its mode, MODE_NONE if the width is illegal.
// - max_addr_width : deepest address width one TDP36K supports at a given data width.
package bram_fifo_pkg;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_36   = 3'b011;
  localparam logic [2:0] MODE_18   = 3'b010;
  localparam logic [2:0] MODE_9    = 3'b001;
  localparam logic [2:0] MODE_4    = 3'b100;
  localparam logic [2:0] MODE_2    = 3'b110;
  localparam logic [2:0] MODE_1    = 3'b101;

  function automatic logic [2:0] width_to_mode(input int unsigned width);
    case (width)
      36:      return MODE_36;
      18:      return MODE_18;
      9:       return MODE_9;
      4:       return MODE_4;
      2:       return MODE_2;
      1:       return MODE_1;
      default: return MODE_NONE;
    endcase
  endfunction

  // 36 Kbit array: width * 2**addr_width must not exceed 36864.
  function automatic int unsigned max_addr_width(input int unsigned width);
    case (width)
      36:      return 10;
      18:      return 11;
      9:       return 12;
      4:       return 13;
      2:       return 14;
      1:       return 15;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/bram_sdp_ram.sv
// Simple-dual-port RAM written in the form the BRAM techmap folds onto a TDP36K.
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset, clears only the read output register
//   we_i     : write enable; waddr_i / wdata_i written at the edge
//   re_i     : read enable; rdata_o loads mem[raddr_i] at the edge, holds otherwise
module bram_sdp_ram #(
  parameter int unsigned DataWidth = 18,
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register reset maps onto the primitive's output-latch reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sync_fifo.sv
// Single-clock FIFO on one block-RAM slice with occupancy, programmable almost flags,
// sticky overflow/underflow and optional first-word-fall-through output.
// Ports:
//   CLK_i, RESET_N_i            : clock, synchronous active-low reset
//   WR_EN_i, WDATA_i            : push request and data
//   RD_EN_i, RDATA_o            : pop request and head/read data
//   FULL_o, EMPTY_o             : count == DEPTH / no word available to the consumer
//   ALMOST_FULL_o/ALMOST_EMPTY_o: count >= DEPTH-AF_OFFSET / count <= AE_OFFSET
//   COUNT_o                     : occupancy (includes the FWFT output word)
//   OVERFLOW_o, UNDERFLOW_o     : sticky until reset
module bram_sync_fifo
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned AF_OFFSET  = 4,
  parameter int unsigned AE_OFFSET  = 4,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  CLK_i,
  input  logic                  RESET_N_i,
  input  logic                  WR_EN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  RD_EN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  FULL_o,
  output logic                  EMPTY_o,
  output logic                  ALMOST_FULL_o,
  output logic                  ALMOST_EMPTY_o,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH + 1)'(DEPTH - AF_OFFSET);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH + 1)'(AE_OFFSET);

  if (width_to_mode(DATA_WIDTH) == MODE_NONE) begin : g_bad_width
    $error("bram_sync_fifo: DATA_WIDTH must be 1, 2, 4, 9, 18 or 36");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > max_addr_width(DATA_WIDTH)) begin : g_bad_depth
    $error("bram_sync_fifo: DATA_WIDTH*DEPTH exceeds one TDP36K");
  end
  if (AF_OFFSET < 1 || AF_OFFSET > DEPTH - 1 || AE_OFFSET < 1 || AE_OFFSET > DEPTH - 1)
  begin : g_bad_offset
    $error("bram_sync_fifo: almost-flag offsets must lie in 1..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, afull_q, aempty_q, ovf_q, unf_q;
  logic                  wr_acc, pop_acc, ram_re, empty_out;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Full rejects writes even when a pop is accepted in the same cycle.
  assign wr_acc = WR_EN_i && !full_q;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, pop_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + ADDR_WIDTH'(1);
      if (ram_re) rptr_q <= rptr_q + ADDR_WIDTH'(1);
      count_q  <= count_d;
      full_q   <= (count_d == FULL_LEVEL);
      afull_q  <= (count_d >= AF_LEVEL);
      aempty_q <= (count_d <= AE_LEVEL);
      if (WR_EN_i && full_q)    ovf_q <= 1'b1;
      if (RD_EN_i && empty_out) unf_q <= 1'b1;
    end
  end

  bram_sdp_ram #(
    .DataWidth(DATA_WIDTH),
    .AddrWidth(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (CLK_i),
    .rst_ni (RESET_N_i),
    .we_i   (wr_acc && RESET_N_i),
    .waddr_i(wptr_q),
    .wdata_i(WDATA_i),
    .re_i   (ram_re && RESET_N_i),
    .raddr_i(rptr_q),
    .rdata_o(ram_dout)
  );

  if (FWFT == 0) begin : g_std
    logic empty_q;

    assign pop_acc   = RD_EN_i && !empty_q;
    assign ram_re    = pop_acc;
    assign empty_out = empty_q;
    assign RDATA_o   = ram_dout;

    always_ff @(posedge CLK_i) begin
      if (!RESET_N_i) empty_q <= 1'b1;
      else            empty_q <= (count_d == '0);
    end
  end else begin : g_fwft
    // Two-stage prefetch: the RAM output register holds an in-flight word (pend_q),
    // the output register holds the head word presented to the consumer (out_valid_q).
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  pend_q, out_valid_q, load;
    logic [DATA_WIDTH-1:0] out_q;

    assign pop_acc   = RD_EN_i && out_valid_q;
    assign load      = pend_q && (!out_valid_q || pop_acc);
    // Only words written at earlier edges are counted, so the prefetch address never
    // equals the address being written this cycle.
    assign ram_re    = (ram_cnt_q != '0) && (!pend_q || load);
    assign empty_out = !out_valid_q;
    assign RDATA_o   = out_q;

    always_comb begin
      ram_cnt_d = ram_cnt_q;
      case ({wr_acc, ram_re})
        2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH + 1)'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase
    end

    always_ff @(posedge CLK_i) begin
      if (!RESET_N_i) begin
        ram_cnt_q   <= '0;
        pend_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        ram_cnt_q   <= ram_cnt_d;
        pend_q      <= ram_re || (pend_q && !load);
        out_valid_q <= load || (out_valid_q && !pop_acc);
        if (load) out_q <= ram_dout;
      end
    end
  end

  assign EMPTY_o        = empty_out;
  assign FULL_o         = full_q;
  assign ALMOST_FULL_o  = afull_q;
  assign ALMOST_EMPTY_o = aempty_q;
  assign COUNT_o        = count_q;
  assign OVERFLOW_o     = ovf_q;
  assign UNDERFLOW_o    = unf_q;

endmodule
